// File: rtl/pipe_pkg.sv
// Shared types for the two-entry skid buffer: occupancy state encoding and depth.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/flopenr.sv
// Enabled register with asynchronous active-high clear to zero.
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic pipeline register: InReady and OutValid decode straight from the
// state register, so neither handshake side sees a combinational path from the other.
module pipe_skid_buffer
    import pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InData,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutData,
    output logic [1:0]       Count
);

    skid_state_t      state_q;
    skid_state_t      state_d;
    logic             in_xfer;
    logic             out_xfer;
    logic             main_en;
    logic             main_from_skid;
    logic             skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign in_xfer  = InValid & InReady;
    assign out_xfer = OutValid & OutReady;
    assign main_d   = main_from_skid ? skid_q : InData;
    assign OutData  = main_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        if (Flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_en = 1'b1;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_en = 1'b1;
                    end else if (in_xfer) begin
                        skid_en = 1'b1;
                        state_d = FULL;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // An illegal encoding refuses input so nothing is silently dropped while recovering.
    always_comb begin
        InReady  = 1'b0;
        OutValid = 1'b0;
        Count    = 2'd0;
        case (state_q)
            EMPTY: begin
                InReady = 1'b1;
            end
            BUSY: begin
                InReady  = 1'b1;
                OutValid = 1'b1;
                Count    = 2'd1;
            end
            FULL: begin
                OutValid = 1'b1;
                Count    = 2'(SKID_DEPTH);
            end
            default: begin
                InReady  = 1'b0;
                OutValid = 1'b0;
                Count    = 2'd0;
            end
        endcase
    end

    flopenr #(.WIDTH(WIDTH)) u_main (
        .clk  (clk),
        .reset(reset),
        .en   (main_en),
        .d    (main_d),
        .q    (main_q)
    );

    flopenr #(.WIDTH(WIDTH)) u_skid (
        .clk  (clk),
        .reset(reset),
        .en   (skid_en),
        .d    (InData),
        .q    (skid_q)
    );

endmodule
